// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC and the jump-target
// LUT, drives a 1-cycle-latency instruction memory, squashes the single
// wrong-path slot after a taken jump and sequences Start/Done.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 16,
    localparam int LUT_AW   = $clog2(LUT_DEPTH)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [PC_W-1:0]    ProgLen,
    input  logic               LutWrEn,
    input  logic [LUT_AW-1:0]  LutWrAddr,
    input  logic [PC_W-1:0]    LutWrData,
    input  logic               pc_jmp_en,
    input  logic [LUT_AW-1:0]  LutPointer,
    output logic [PC_W-1:0]    ImemAddr,
    input  logic [INSTR_W-1:0] ImemData,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    output logic [PC_W-1:0]    InstrPc,
    output logic               Done
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic [PC_W-1:0]   r_instr_pc, w_instr_pc_nxt;
    logic              r_instr_valid, w_instr_valid_nxt;
    logic              r_done, w_done_nxt;
    logic [PC_W-1:0]   r_lut [LUT_DEPTH];

    logic              w_take;
    logic              w_last;
    logic              w_lut_we;
    logic [PC_W-1:0]   w_target;

    // A bubble slot (InstrValid=0) can never redirect, so a held jump
    // request during the squash cycle is harmless.
    assign w_take   = r_instr_valid & pc_jmp_en;
    // ProgLen-1 truncated to PC_W, so ProgLen=2^PC_W (encoded as 0) ends at the top address.
    assign w_last   = (r_instr_pc == (ProgLen - PC_W'(1)));
    assign w_lut_we = LutWrEn & ((r_state == IDLE) | (r_state == DONE));
    assign w_target = r_lut[LutPointer];

    assign ImemAddr   = r_pc;
    assign Instr      = r_instr_valid ? ImemData : '0;
    assign InstrValid = r_instr_valid;
    assign InstrPc    = r_instr_pc;
    assign Done       = r_done;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and next-PC / issue-slot logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = 1'b0;
        w_done_nxt        = r_done;
        case (r_state)
            IDLE, DONE: begin
                if (Start) begin
                    w_state_nxt = PRIME;
                    w_pc_nxt    = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            PRIME: begin
                w_state_nxt       = RUN;
                w_pc_nxt          = PC_W'(1);
                w_instr_pc_nxt    = '0;
                w_instr_valid_nxt = 1'b1;
            end
            RUN: begin
                if (w_take) begin
                    // Redirect; the PC+1 fetch already in flight is squashed.
                    w_pc_nxt          = w_target;
                    w_instr_pc_nxt    = w_target;
                    w_instr_valid_nxt = 1'b0;
                end else begin
                    w_pc_nxt          = r_pc + PC_W'(1);
                    w_instr_pc_nxt    = r_pc;
                    w_instr_valid_nxt = 1'b1;
                    // Only a real, non-jumping last instruction completes the run.
                    if (r_instr_valid && w_last) begin
                        w_state_nxt       = DONE;
                        w_done_nxt        = 1'b1;
                        w_instr_valid_nxt = 1'b0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // PC, issue slot and Done registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc          <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // Jump-target LUT; writable only while no program is running.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) r_lut[i] <= '0;
        end else if (w_lut_we) begin
            r_lut[LutWrAddr] <= LutWrData;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven vectors for straight-line, jump, squash and
// write/start gating, plus hand sequences for reset mid-run, same-cycle
// LUT write with Start, and PC wrap on a 4-bit PC instance.
module tb_fetch_unit;

    logic       Clk = 0;
    logic       Reset;
    logic       Start;
    logic [9:0] ProgLen;
    logic       LutWrEn;
    logic [3:0] LutWrAddr;
    logic [9:0] LutWrData;
    logic       pc_jmp_en;
    logic [3:0] LutPointer;
    logic [9:0] ImemAddr;
    logic [8:0] ImemData;
    logic [8:0] Instr;
    logic       InstrValid;
    logic [9:0] InstrPc;
    logic       Done;

    logic       Start4;
    logic [3:0] ImemAddr4;
    logic [8:0] ImemData4;
    logic [8:0] Instr4;
    logic       InstrValid4;
    logic [3:0] InstrPc4;
    logic       Done4;

    int nvec = 0;
    int nerr = 0;

    always #5 Clk = ~Clk;

    fetch_unit u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgLen(ProgLen),
        .LutWrEn(LutWrEn), .LutWrAddr(LutWrAddr), .LutWrData(LutWrData),
        .pc_jmp_en(pc_jmp_en), .LutPointer(LutPointer),
        .ImemAddr(ImemAddr), .ImemData(ImemData), .Instr(Instr),
        .InstrValid(InstrValid), .InstrPc(InstrPc), .Done(Done)
    );

    // 4-bit PC instance; ProgLen=16 truncates to 0.
    fetch_unit #(.PC_W(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start4), .ProgLen(4'd0),
        .LutWrEn(1'b0), .LutWrAddr(4'd0), .LutWrData(4'd0),
        .pc_jmp_en(1'b0), .LutPointer(4'd0),
        .ImemAddr(ImemAddr4), .ImemData(ImemData4), .Instr(Instr4),
        .InstrValid(InstrValid4), .InstrPc(InstrPc4), .Done(Done4)
    );

    // Instruction memory contents: arbitrary non-trivial encoding per address.
    function automatic logic [8:0] memf(input int a);
        return 9'((a * 7 + 3) & 511);
    endfunction

    // Synchronous memories, 1-cycle read latency.
    always @(posedge Clk) begin
        ImemData  <= memf(int'(ImemAddr));
        ImemData4 <= memf(int'(ImemAddr4));
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        bit        st;
        bit        we;
        logic [3:0] wa;
        logic [9:0] wd;
        logic [9:0] pl;
        bit        j;
        logic [3:0] p;
        int        addr;   // -1: don't care
        bit        vld;
        int        ipc;    // -1: don't care
        bit        done;
    } vec_t;

    function automatic vec_t mk(input bit st, input bit we, input int wa, input int wd,
                                input int pl, input bit j, input int p,
                                input int addr, input bit vld, input int ipc, input bit done);
        vec_t v;
        v.st = st; v.we = we; v.wa = 4'(wa); v.wd = 10'(wd); v.pl = 10'(pl);
        v.j = j; v.p = 4'(p); v.addr = addr; v.vld = vld; v.ipc = ipc; v.done = done;
        return v;
    endfunction

    vec_t tv [19];

    initial begin
        // Straight line, ProgLen=4.
        tv[0]  = mk(1,0,0,0, 4, 0,0,   0,0, 0,0);
        tv[1]  = mk(0,0,0,0, 4, 0,0,   1,1, 0,0);
        tv[2]  = mk(0,0,0,0, 4, 0,0,   2,1, 1,0);
        tv[3]  = mk(0,0,0,0, 4, 0,0,   3,1, 2,0);
        tv[4]  = mk(0,0,0,0, 4, 0,0,   4,1, 3,0);
        tv[5]  = mk(0,0,0,0, 4, 0,0,  -1,0,-1,1);
        tv[6]  = mk(0,0,0,0, 4, 0,0,  -1,0,-1,1);
        // LUT[5]=8 in DONE, then run with ProgLen=10.
        tv[7]  = mk(0,1,5,8,10, 0,0,  -1,0,-1,1);
        tv[8]  = mk(1,0,0,0,10, 0,0,   0,0,-1,0);
        tv[9]  = mk(0,0,0,0,10, 0,0,   1,1, 0,0);
        tv[10] = mk(0,0,0,0,10, 0,0,   2,1, 1,0);
        tv[11] = mk(0,0,0,0,10, 0,0,   3,1, 2,0);
        // Jump at InstrPc=2 via pointer 5 -> squash slot.
        tv[12] = mk(0,0,0,0,10, 1,5,   8,0, 8,0);
        // Jump held through squash, plus a dropped LUT write.
        tv[13] = mk(0,1,5,1,10, 1,5,   9,1, 8,0);
        // Start during RUN ignored.
        tv[14] = mk(1,0,0,0,10, 0,0,  10,1, 9,0);
        // Jump at last instruction: still targets 8, no completion.
        tv[15] = mk(0,0,0,0,10, 1,5,   8,0, 8,0);
        tv[16] = mk(0,0,0,0,10, 0,0,   9,1, 8,0);
        tv[17] = mk(0,0,0,0,10, 0,0,  10,1, 9,0);
        tv[18] = mk(0,0,0,0,10, 0,0,  -1,0,-1,1);

        Reset = 1; Start = 0; Start4 = 0; ProgLen = 10'd4;
        LutWrEn = 0; LutWrAddr = 0; LutWrData = 0; pc_jmp_en = 0; LutPointer = 0;
        step(); step();
        Reset = 0;
        chk("rst_addr", int'(ImemAddr), 0);
        chk("rst_valid", int'(InstrValid), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_ipc", int'(InstrPc), 0);
        chk("rst_instr", int'(Instr), 0);

        for (int i = 0; i < 19; i++) begin
            Start = tv[i].st; LutWrEn = tv[i].we; LutWrAddr = tv[i].wa;
            LutWrData = tv[i].wd; ProgLen = tv[i].pl;
            pc_jmp_en = tv[i].j; LutPointer = tv[i].p;
            step();
            if (tv[i].addr >= 0) chk($sformatf("v%0d_addr", i), int'(ImemAddr), tv[i].addr);
            chk($sformatf("v%0d_valid", i), int'(InstrValid), int'(tv[i].vld));
            if (tv[i].ipc >= 0) chk($sformatf("v%0d_ipc", i), int'(InstrPc), tv[i].ipc);
            chk($sformatf("v%0d_done", i), int'(Done), int'(tv[i].done));
            chk($sformatf("v%0d_instr", i), int'(Instr),
                tv[i].vld ? int'(memf(tv[i].ipc)) : 0);
        end
        Start = 0; LutWrEn = 0; pc_jmp_en = 0;

        // Reset held 2 cycles mid-run.
        Start = 1; step(); Start = 0;
        step(); step(); step();
        chk("mid_ipc_pre", int'(InstrPc), 2);
        Reset = 1; step();
        chk("mr_addr", int'(ImemAddr), 0);
        chk("mr_valid", int'(InstrValid), 0);
        chk("mr_done", int'(Done), 0);
        chk("mr_ipc", int'(InstrPc), 0);
        step(); Reset = 0;
        chk("mr2_addr", int'(ImemAddr), 0);

        // Start with same-cycle LUT write in IDLE; LUT[5] was cleared by reset.
        Start = 1; LutWrEn = 1; LutWrAddr = 3; LutWrData = 10'd20; ProgLen = 10'd30;
        step();
        Start = 0; LutWrEn = 0;
        chk("ss_prime_addr", int'(ImemAddr), 0);
        step();
        chk("ss_ipc0", int'(InstrPc), 0);
        chk("ss_v0", int'(InstrValid), 1);
        pc_jmp_en = 1; LutPointer = 5;
        step();
        chk("clr_lut_addr", int'(ImemAddr), 0);
        chk("clr_lut_valid", int'(InstrValid), 0);
        LutPointer = 3;
        step();
        chk("sq_ignore_addr", int'(ImemAddr), 1);
        chk("sq_ignore_ipc", int'(InstrPc), 0);
        chk("sq_ignore_valid", int'(InstrValid), 1);
        step();
        chk("new_lut_addr", int'(ImemAddr), 20);
        chk("new_lut_ipc", int'(InstrPc), 20);
        chk("new_lut_instr", int'(Instr), 0);
        pc_jmp_en = 0;
        step();
        chk("after_bub_addr", int'(ImemAddr), 21);
        chk("after_bub_ipc", int'(InstrPc), 20);
        chk("after_bub_instr", int'(Instr), int'(memf(20)));

        // 4-bit PC wrap with ProgLen=16.
        Start4 = 1; step(); Start4 = 0;
        chk("w_prime_addr", int'(ImemAddr4), 0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("w%0d_ipc", k), int'(InstrPc4), k);
            chk($sformatf("w%0d_valid", k), int'(InstrValid4), 1);
            chk($sformatf("w%0d_addr", k), int'(ImemAddr4), (k + 1) % 16);
            chk($sformatf("w%0d_done", k), int'(Done4), 0);
            chk($sformatf("w%0d_instr", k), int'(Instr4), int'(memf(k)));
        end
        step();
        chk("w_done", int'(Done4), 1);
        chk("w_done_valid", int'(InstrValid4), 0);
        step();
        chk("w_done_hold", int'(Done4), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
